// File: rtl/pe_rx_checker.sv
// pe_rx_checker: mesh PE receive sink with rate-limited FIFO drain, destination check and payload checksum
module pe_rx_checker #(
    parameter int XCORD             = 0,
    parameter int YCORD             = 0,
    parameter int X                 = 2,
    parameter int Y                 = 2,
    parameter int x_size            = $clog2(X),
    parameter int y_size            = $clog2(Y),
    parameter int pkt_no_field_size = 8,
    parameter int data_width        = 256,
    parameter int total_width       = x_size + y_size + pkt_no_field_size + data_width,
    parameter int FIFO_DEPTH        = 4,
    parameter int DRAIN_RATE        = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_valid,
    input  logic [total_width-1:0] i_data,
    output logic                   o_ready,
    input  logic                   start,
    input  logic                   enable,
    input  logic [31:0]            expected_count,
    output logic [31:0]            received_count,
    output logic [15:0]            err_count,
    output logic [data_width-1:0]  checksum,
    output logic [(pkt_no_field_size > 0 ? pkt_no_field_size : 1)-1:0] last_pkt_no,
    output logic                   error,
    output logic                   done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DRAIN_RATE) + 1;
    localparam int PW = pkt_no_field_size > 0 ? pkt_no_field_size : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nx;
    logic [total_width-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [DW-1:0]          drain;
    logic [31:0]            exp_q, rcnt_nx;
    logic [total_width-1:0] head;
    logic [x_size-1:0]      dst_x;
    logic [y_size-1:0]      dst_y;
    logic [PW-1:0]          pkt;
    logic [data_width-1:0]  payload;
    logic                   full, empty, push, pop, hit, launch, mismatch;

    assign full     = cnt == CW'(FIFO_DEPTH);
    assign empty    = cnt == '0;
    assign o_ready  = (state == RUN) & enable & !full;
    assign push     = i_valid & o_ready;
    assign pop      = (state == RUN) & !empty & (drain == '0);
    assign launch   = start & (state != RUN);
    assign cnt_nx   = cnt + CW'(push) - CW'(pop);
    assign rcnt_nx  = received_count + 32'd1;
    assign hit      = pop & (rcnt_nx == exp_q);
    assign done     = state == DONE;
    assign head     = mem[rd_ptr];
    assign dst_x    = head[x_size-1:0];
    assign dst_y    = head[x_size +: y_size];
    assign payload  = head[total_width-1 -: data_width];
    assign mismatch = (dst_x != x_size'(XCORD)) | (dst_y != y_size'(YCORD));

    if (pkt_no_field_size > 0) begin : g_pkt
        assign pkt = head[x_size + y_size +: pkt_no_field_size];
    end else begin : g_nopkt
        assign pkt = '0;
    end

    // next state: a zero-length run goes straight to DONE so o_ready never rises
    always_comb begin
        state_nx = launch ? (expected_count == '0 ? DONE : RUN) : hit ? DONE : state;
    end

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    // FIFO pointers and drain pacing; flushed on run launch and on DONE entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            drain  <= '0;
        end else begin
            wr_ptr <= (launch | hit) ? '0 : wr_ptr + AW'(push);
            rd_ptr <= (launch | hit) ? '0 : rd_ptr + AW'(pop);
            cnt    <= (launch | hit) ? '0 : cnt_nx;
            drain  <= launch ? '0 : pop ? DW'(DRAIN_RATE - 1) : (drain != '0) ? drain - DW'(1) : drain;
        end
    end

    // run statistics; leftover FIFO entries at completion count as excess flits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q          <= '0;
            received_count <= '0;
            err_count      <= '0;
            checksum       <= '0;
            last_pkt_no    <= '0;
            error          <= 1'b0;
        end else if (launch) begin
            exp_q          <= expected_count;
            received_count <= '0;
            err_count      <= '0;
            checksum       <= '0;
            last_pkt_no    <= '0;
            error          <= 1'b0;
        end else if (pop) begin
            received_count <= rcnt_nx;
            checksum       <= checksum ^ payload;
            last_pkt_no    <= pkt;
            err_count      <= (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
            error          <= error | mismatch | (hit & (cnt_nx != '0));
        end
    end
endmodule
